vector_alu_seq: RTL and testbench



---
 rtl/vector_alu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_vector_alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: multi-cycle vector ALU that processes NUM_ELEMS elements of
// WIDTH bits through LANES scalar slices over ceil(NUM_ELEMS/LANES) beats.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low
//   start      request, accepted only in IDLE
//   op         0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 PASS (result = a)
//   vv_mode    0: b = imm32 for every element, 1: b = vec_b element
//   imm32      scalar operand
//   vec_a      packed vector, element i at [i*WIDTH +: WIDTH]
//   vec_b      packed vector, same layout
//   busy       high in RUN and DONE
//   done       one-cycle pulse when results are complete
//   result     packed results, same layout as vec_a
//   ALUFlags   {N,Z,C,V} of element NUM_ELEMS-1
//   zero_mask  bit i set when result element i is zero
//   reduce_sum wrapping sum of all results (only with VEC_ALU_REDUCE_EN)
//
// Optional feature macro: VEC_ALU_REDUCE_EN
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// RUN   | one beat per cycle, LANES elements written per beat
// DONE  | results complete, done pulses for this one cycle

module vector_alu_seq #(
    parameter int WIDTH     = 32,
    parameter int NUM_ELEMS = 5,
    parameter int LANES     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic                       vv_mode,
    input  logic [WIDTH-1:0]           imm32,
    input  logic [NUM_ELEMS*WIDTH-1:0] vec_a,
    input  logic [NUM_ELEMS*WIDTH-1:0] vec_b,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_ELEMS*WIDTH-1:0] result,
    output logic [3:0]                 ALUFlags,
    output logic [NUM_ELEMS-1:0]       zero_mask
`ifdef VEC_ALU_REDUCE_EN
    ,
    output logic [WIDTH-1:0]           reduce_sum
`endif
);

    localparam int BEATS  = (NUM_ELEMS + LANES - 1) / LANES;
    localparam int TOT    = BEATS * LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               state, state_n;
    logic [BEAT_W-1:0]    beat;
    logic                 last_beat;
    logic                 accept;

    logic [2:0]           op_q;
    logic                 vv_q;
    logic [WIDTH-1:0]     imm_q;
    // Operands are padded to a whole number of beats so idle lanes on the
    // final partial beat always read in-range (zero) data.
    logic [TOT*WIDTH-1:0] a_q, b_q;

    logic [NUM_ELEMS*WIDTH-1:0] res_q;
    logic [NUM_ELEMS-1:0]       zmask_q;
    logic [3:0]                 flags_q;

    int                   lane_idx [LANES];
    logic [WIDTH+3:0]     lane_out [LANES];

    // Returns {N, Z, C, V, result}.
    function automatic logic [WIDTH+3:0] alu_slice(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        sum = '0;
        r   = a;
        c   = 1'b0;
        v   = 1'b0;
        case (f_op)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {r[WIDTH-1], (r == '0), c, v, r};
    endfunction

    assign accept    = (state == ST_IDLE) && start;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_beat) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Element handled by each lane on the current beat
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = int'(beat) * LANES + l;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_out[l] = alu_slice(op_q,
                                    a_q[lane_idx[l]*WIDTH +: WIDTH],
                                    vv_q ? b_q[lane_idx[l]*WIDTH +: WIDTH] : imm_q);
        end
    end

`ifdef VEC_ALU_REDUCE_EN
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_idx[l] < NUM_ELEMS) begin
                beat_sum = beat_sum + lane_out[l][WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (state == ST_RUN) begin
            sum_q <= sum_q + beat_sum;
        end
    end

    assign reduce_sum = sum_q;
`endif

    // Operand latch, beat counter and per-element result write-back
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat    <= '0;
            op_q    <= '0;
            vv_q    <= 1'b0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zmask_q <= '0;
            flags_q <= '0;
        end else if (accept) begin
            beat  <= '0;
            op_q  <= op;
            vv_q  <= vv_mode;
            imm_q <= imm32;
            a_q   <= (TOT*WIDTH)'(vec_a);
            b_q   <= (TOT*WIDTH)'(vec_b);
        end else if (state == ST_RUN) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_idx[l] < NUM_ELEMS) begin
                    res_q[lane_idx[l]*WIDTH +: WIDTH] <= lane_out[l][WIDTH-1:0];
                    zmask_q[lane_idx[l] +: 1]         <= lane_out[l][WIDTH+2];
                    if (lane_idx[l] == NUM_ELEMS - 1) begin
                        flags_q <= lane_out[l][WIDTH+3:WIDTH];
                    end
                end
            end
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    assign result    = res_q;
    assign zero_mask = zmask_q;
    assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq: a LANES=2 instance (3 beats) and a
// LANES=5 instance (1 beat) share operand inputs but have separate starts.
module tb_vector_alu_seq;

    logic         clk;
    logic         reset;
    logic         start2, start5;
    logic [2:0]   op;
    logic         vv;
    logic [31:0]  imm;
    logic [159:0] va, vb;

    logic         busy2, done2, busy5, done5;
    logic [159:0] res2, res5;
    logic [3:0]   flags2, flags5;
    logic [4:0]   zm2, zm5;
`ifdef VEC_ALU_REDUCE_EN
    logic [31:0]  rs2, rs5;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    vector_alu_seq #(.WIDTH(32), .NUM_ELEMS(5), .LANES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op), .vv_mode(vv),
        .imm32(imm), .vec_a(va), .vec_b(vb), .busy(busy2), .done(done2),
        .result(res2), .ALUFlags(flags2), .zero_mask(zm2)
`ifdef VEC_ALU_REDUCE_EN
        , .reduce_sum(rs2)
`endif
    );

    vector_alu_seq #(.WIDTH(32), .NUM_ELEMS(5), .LANES(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .op(op), .vv_mode(vv),
        .imm32(imm), .vec_a(va), .vec_b(vb), .busy(busy5), .done(done5),
        .result(res5), .ALUFlags(flags5), .zero_mask(zm5)
`ifdef VEC_ALU_REDUCE_EN
        , .reduce_sum(rs5)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] pack5(input logic [31:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation and check busy/done timing through return to IDLE.
    task automatic run_op(input logic use5, input logic [2:0] o, input logic v,
                          input logic [31:0] im, input logic [159:0] a, input logic [159:0] b);
        int nb;
        nb  = use5 ? 1 : 3;
        op  = o;
        vv  = v;
        imm = im;
        va  = a;
        vb  = b;
        if (use5) start5 = 1'b1;
        else      start2 = 1'b1;
        tick();
        start2 = 1'b0;
        start5 = 1'b0;
        // operands changed after accept must not matter
        va  = ~a;
        vb  = ~b;
        imm = ~im;
        for (int k = 1; k <= nb; k++) begin
            tick();
            chk("busy_run", 160'(use5 ? busy5 : busy2), 160'(1'b1));
            chk((k == nb) ? "done_on" : "done_early", 160'(use5 ? done5 : done2),
                160'(k == nb));
        end
        tick();
        chk("done_off", 160'(use5 ? done5 : done2), 160'(1'b0));
        chk("busy_off", 160'(use5 ? busy5 : busy2), 160'(1'b0));
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b0;
        start2 = 1'b0;
        start5 = 1'b0;
        op     = 3'd0;
        vv     = 1'b0;
        imm    = '0;
        va     = '0;
        vb     = '0;
        tick();
        tick();
        chk("rst_busy",  160'(busy2),  160'(1'b0));
        chk("rst_done",  160'(done2),  160'(1'b0));
        chk("rst_res",   res2,         160'(0));
        chk("rst_zm",    160'(zm2),    160'(0));
        chk("rst_flags", 160'(flags2), 160'(0));
        reset = 1'b1;
        tick();

        // ADD imm=1, carry out of last element
        run_op(1'b0, 3'd0, 1'b0, 32'd1, pack5(0, 1, 2, 3, 32'hFFFF_FFFF), '0);
        chk("t1_res",   res2,         pack5(1, 2, 3, 4, 0));
        chk("t1_zm",    160'(zm2),    160'(5'b10000));
        chk("t1_flags", 160'(flags2), 160'(4'b0110));

        // SUB vector-vector
        run_op(1'b0, 3'd1, 1'b1, 32'd0, pack5(5, 5, 5, 5, 5), pack5(5, 6, 0, 1, 5));
        chk("t2_res",   res2,         pack5(0, 32'hFFFF_FFFF, 5, 4, 0));
        chk("t2_zm",    160'(zm2),    160'(5'b10001));
        chk("t2_flags", 160'(flags2), 160'(4'b0110));

        // ADD signed overflow on last element
        run_op(1'b0, 3'd0, 1'b0, 32'd1, pack5(10, 20, 30, 40, 32'h7FFF_FFFF), '0);
        chk("t3_res",   res2,         pack5(11, 21, 31, 41, 32'h8000_0000));
        chk("t3_zm",    160'(zm2),    160'(5'b00000));
        chk("t3_flags", 160'(flags2), 160'(4'b1001));

        // start while busy is ignored
        op = 3'd0; vv = 1'b0; imm = 32'd1; va = pack5(1, 2, 3, 4, 5); vb = '0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        chk("t4_busy1", 160'(busy2), 160'(1'b1));
        start2 = 1'b1; op = 3'd4; vv = 1'b1; imm = 32'hFFFF; va = pack5(9, 9, 9, 9, 9);
        vb = pack5(7, 7, 7, 7, 7);
        tick();
        chk("t4_done_early", 160'(done2), 160'(1'b0));
        tick();
        chk("t4_done_on", 160'(done2), 160'(1'b1));
        start2 = 1'b0;
        tick();
        chk("t4_done_off", 160'(done2), 160'(1'b0));
        chk("t4_busy_off", 160'(busy2), 160'(1'b0));
        tick();
        chk("t4_no_retrig", 160'(busy2), 160'(1'b0));
        chk("t4_res",   res2,         pack5(2, 3, 4, 5, 6));
        chk("t4_flags", 160'(flags2), 160'(4'b0000));
        chk("t4_zm",    160'(zm2),    160'(5'b00000));
`ifdef VEC_ALU_REDUCE_EN
        chk("t4_reduce", 160'(rs2), 160'(32'd20));
`endif

        // reset mid-RUN at beat 1
        op = 3'd0; vv = 1'b0; imm = 32'd3; va = pack5(1, 1, 1, 1, 1);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t5_busy",  160'(busy2),  160'(1'b0));
        chk("t5_done",  160'(done2),  160'(1'b0));
        chk("t5_res",   res2,         160'(0));
        chk("t5_zm",    160'(zm2),    160'(0));
        chk("t5_flags", 160'(flags2), 160'(0));
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_done", 160'(done2), 160'(1'b0));
        end

        // LANES=5: single beat
        run_op(1'b1, 3'd2, 1'b0, 32'h0F, pack5(32'h1234, 32'hF0, 32'hFF, 0, 32'hABCD_EF07), '0);
        chk("t6_and_res",   res5,         pack5(4, 0, 32'hF, 0, 7));
        chk("t6_and_zm",    160'(zm5),    160'(5'b01010));
        chk("t6_and_flags", 160'(flags5), 160'(4'b0000));

        run_op(1'b1, 3'd6, 1'b1, 32'hFFFF_FFFF, pack5(5, 0, 7, 9, 32'h8000_0000),
               pack5(1, 1, 1, 1, 1));
        chk("t6_pass_res",   res5,         pack5(5, 0, 7, 9, 32'h8000_0000));
        chk("t6_pass_zm",    160'(zm5),    160'(5'b00010));
        chk("t6_pass_flags", 160'(flags5), 160'(4'b1000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
